// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one block-RAM port among NREQ valid/ready requesters
module bram_port_arbiter #(
   parameter int NREQ   = 4,
   parameter int IDW    = 2,
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   hold,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*AWIDTH-1:0] req_addr,
   input  logic [NREQ*DWIDTH-1:0] req_wdata,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [AWIDTH-1:0]      mem_addr,
   output logic [DWIDTH-1:0]      mem_din,
   input  logic [DWIDTH-1:0]      mem_dout,
   output logic                   rsp_valid,
   output logic [IDW-1:0]         rsp_id,
   output logic                   rsp_we,
   output logic [DWIDTH-1:0]      rsp_rdata
);
   if (IDW != $clog2(NREQ)) $error("IDW must equal clog2(NREQ)");
   logic [IDW-1:0] last_id, gnt_id, idx;
   logic gnt;
   // descending scan so the candidate nearest last_id+1 is written last and wins
   always_comb begin
      gnt = 1'b0;
      gnt_id = '0;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDW'((int'(last_id) + k) % NREQ);
         if (req_valid[idx]) begin
            gnt = 1'b1;
            gnt_id = idx;
         end
      end
      if (hold || !rst_n) gnt = 1'b0;
   end
   assign req_ready = gnt ? NREQ'(1) << gnt_id : '0;
   assign mem_en    = gnt;
   assign mem_we    = gnt & req_we[gnt_id];
   assign mem_addr  = gnt ? req_addr[int'(gnt_id)*AWIDTH +: AWIDTH] : '0;
   assign mem_din   = gnt ? req_wdata[int'(gnt_id)*DWIDTH +: DWIDTH] : '0;
   assign rsp_rdata = mem_dout;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_id   <= IDW'(NREQ - 1);
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_we    <= 1'b0;
      end else begin
         rsp_valid <= gnt;
         if (gnt) begin
            last_id <= gnt_id;
            rsp_id  <= gnt_id;
            rsp_we  <= req_we[gnt_id];
         end
      end
   end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed stimulus with a response scoreboard against a read-first RAM model
module tb_bram_port_arbiter;
   logic clk, rst_n, hold;
   logic [3:0] req_valid, req_ready, req_we;
   logic [39:0] req_addr;
   logic [127:0] req_wdata;
   logic mem_en, mem_we, rsp_valid, rsp_we;
   logic [9:0] mem_addr;
   logic [31:0] mem_din, mem_dout, rsp_rdata;
   logic [1:0] rsp_id;
   logic [9:0] a [4];
   logic [31:0] wd [4];
   logic [31:0] mem [1024];
   typedef struct {int id; logic we; logic [31:0] d;} exp_t;
   exp_t q[$];
   int n_chk = 0, n_fail = 0;
   bram_port_arbiter dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always_comb
      for (int i = 0; i < 4; i++) begin
         req_addr[i*10 +: 10] = a[i];
         req_wdata[i*32 +: 32] = wd[i];
      end
   // read-first RAM with registered output
   always @(posedge clk)
      if (mem_en) begin
         mem_dout <= mem[mem_addr];
         if (mem_we) mem[mem_addr] <= mem_din;
      end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk)
      if (rsp_valid) begin
         if (q.size() == 0) chk("unexpected_rsp", {rsp_id, rsp_we}, 64'hFFFF);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_we", rsp_we, e.we);
            chk("rsp_rdata", rsp_rdata, e.d);
         end
      end
   task automatic expect_grant(input int g, input logic [31:0] d);
      logic [3:0] er;
      #1;
      er = g < 0 ? 4'b0 : 4'(1) << g;
      chk("req_ready", req_ready, er);
      chk("mem_en", mem_en, g >= 0);
      chk("mem_we", mem_we, g >= 0 ? req_we[g] : 1'b0);
      chk("mem_addr", mem_addr, g >= 0 ? a[g] : 10'h0);
      chk("mem_din", mem_din, g >= 0 ? wd[g] : 32'h0);
      if (g >= 0) q.push_back('{id: g, we: req_we[g], d: d});
      @(posedge clk);
      #1;
   endtask
   task automatic set_reads;
      req_we = 4'b0;
      for (int i = 0; i < 4; i++) begin
         a[i] = 10'h10 + 10'(i);
         wd[i] = 32'h0;
      end
   endtask
   initial begin
      int rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int sk[4] = '{1, 3, 1, 3};
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
      rst_n = 1'b0;
      hold = 1'b0;
      req_valid = 4'hF;
      set_reads();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", req_ready, 4'h0);
      chk("reset_mem_en", mem_en, 1'b0);
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) expect_grant(rr[k], 32'hA000_0010 + 32'(rr[k]));
      req_valid = 4'b1010;
      for (int k = 0; k < 4; k++) expect_grant(sk[k], 32'hA000_0010 + 32'(sk[k]));
      req_valid = 4'b0;
      expect_grant(-1, 0);
      req_valid = 4'b0100;
      req_we[2] = 1'b1;
      a[2] = 10'h005;
      wd[2] = 32'hDEAD_BEEF;
      expect_grant(2, 32'hA000_0005);
      req_we[2] = 1'b0;
      expect_grant(2, 32'hDEAD_BEEF);
      set_reads();
      req_valid = 4'hF;
      expect_grant(3, 32'hA000_0013);
      hold = 1'b1;
      repeat (3) expect_grant(-1, 0);
      hold = 1'b0;
      expect_grant(0, 32'hA000_0010);
      expect_grant(1, 32'hA000_0011);
      req_valid = 4'b0001;
      a[0] = 10'h005;
      expect_grant(0, 32'hDEAD_BEEF);
      rst_n = 1'b0;
      #1;
      chk("midreset_rsp_valid", rsp_valid, 1'b0);
      q.delete();
      req_valid = 4'hF;
      a[0] = 10'h010;
      #1;
      chk("midreset_ready", req_ready, 4'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      expect_grant(0, 32'hA000_0010);
      req_valid = 4'b0100;
      a[2] = 10'h005;
      expect_grant(2, 32'hDEAD_BEEF);
      req_valid = 4'b0;
      expect_grant(-1, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one port of the dual-port block RAM between `NREQ` requesters on a single clock. Each requester issues read or write commands over a valid/ready handshake. The arbiter grants at most one command per cycle and drives the RAM port directly. It returns the one-cycle-latency RAM output tagged with the requester ID. It sits between the compute/DMA engines and RAM port A; port B remains dedicated to a separate agent.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8)
- `IDW`, 2: requester ID width, must equal ceil(log2(NREQ))
- `AWIDTH`, 10: RAM address width
- `DWIDTH`, 32: RAM data width

Ports:
- `clk`  in  1  single clock; all logic is posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `hold`  in  1  when 1, no grants are issued
- `req_valid`  in  NREQ  per-requester command valid
- `req_ready`  out  NREQ  per-requester grant, one-hot or zero
- `req_we`  in  NREQ  per-requester write (1) / read (0)
- `req_addr`  in  NREQ*AWIDTH  flattened addresses; requester i at [i*AWIDTH +: AWIDTH]
- `req_wdata`  in  NREQ*DWIDTH  flattened write data; requester i at [i*DWIDTH +: DWIDTH]
- `mem_en`  out  1  to RAM port enable
- `mem_we`  out  1  to RAM port write enable
- `mem_addr`  out  AWIDTH  to RAM port address
- `mem_din`  out  DWIDTH  to RAM port write data
- `mem_dout`  in  DWIDTH  from RAM port data output (registered inside RAM)
- `rsp_valid`  out  1  response valid; no backpressure
- `rsp_id`  out  IDW  requester that issued the responded command
- `rsp_we`  out  1  1 = write acknowledge, 0 = read data
- `rsp_rdata`  out  DWIDTH  equal to `mem_dout`

## Operation
- **Arbitration:** combinational round-robin over `req_valid`.
  - Search starts at `(last_id+1) mod NREQ`, wrapping; the first asserted requester wins.
  - `req_ready[g]=1` for the winner only.
  - All `req_ready` are 0 when `hold=1`, when no request is pending, or while `rst_n=0`.
- **Acceptance:** a command is accepted when `req_valid[i] & req_ready[i]` at a rising edge. On acceptance `last_id <= g`. Requesters must hold valid/we/addr/wdata stable until accepted.
- **RAM drive:** combinational from the grant.
  - On a grant: `mem_en=1`, `mem_we=req_we[g]`, `mem_addr`/`mem_din` = slice g.
  - With no grant: `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`.
- **Response tracking:** registered. At the acceptance edge, `rsp_valid<=1`, `rsp_id<=g`, `rsp_we<=req_we[g]`. With no acceptance, `rsp_valid<=0`; `rsp_id`/`rsp_we` hold their values.
- **Read data:** `rsp_rdata = mem_dout` combinationally.
  - The RAM is read-first, so a write response carries the old word at that address.
  - A read accepted the cycle after a write to the same address returns the new data.
- **Fairness:** a requester holding `req_valid` continuously is granted within `NREQ` accepting cycles.
- **`hold`:** takes effect the same cycle it rises. Responses for commands already accepted still appear. `last_id` is unchanged while held.
- **Port B:** collisions with port B (same address, same cycle) are the system's responsibility and are not detected here.

## Timing
- Reset values (asynchronous, immediate): `rsp_valid=0`, `rsp_id=0`, `rsp_we=0`, `last_id=NREQ-1` (requester 0 has first priority). Combinational outputs follow from `req_ready=0`: `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`.
- **Latency:** command accepted at edge T means `rsp_valid=1` in cycle T+1 with `mem_dout` valid in that same cycle.
- **Throughput:** one command per cycle, back-to-back, any mix of reads and writes.
- **Reset mid-operation:** an in-flight response is dropped (`rsp_valid` cleared asynchronously). After `rst_n` rises, arbitration restarts with priority at requester 0.
- **`NREQ` wrap:** after a grant to requester `NREQ-1`, the search starts at requester 0.

## Test plan
- **Reset/idle:** assert `rst_n=0` with all `req_valid=1` -> all `req_ready=0`, `mem_en=0`, `rsp_valid=0`. Release reset -> requester 0 granted first.
- **Single write then read:**
  - Requester 2 writes 0xDEADBEEF to addr 0x05 at edge T -> `rsp_valid=1`, `rsp_id=2`, `rsp_we=1` at T+1.
  - Requester 2 reads addr 0x05 at edge T+1 -> `rsp_rdata=0xDEADBEEF`, `rsp_we=0` at T+2.
- **Round-robin:** all four requesters hold `req_valid=1` for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Every `rsp_id` matches the grant order, delayed by one cycle.
- **Wrap and skip:** only requesters 1 and 3 valid after `last_id=3` -> order 1,3,1,3, with no idle cycles.
- **`hold`:** assert `hold` for 3 cycles during contention -> `req_ready=0` and `mem_en=0` for those 3 cycles. The response from the pre-hold grant still appears. After release, the grant continues from `last_id+1`.
- **Reset mid-read:** pull `rst_n` low in the cycle after a read is accepted -> `rsp_valid` drops immediately. After release, requester 0 has priority and memory contents are unchanged.
